// File: rtl/dmem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_bus_arbiter
// Description : Two-master arbiter for the single data-memory port. The CPU
//               MEM stage has priority, DMA steals idle cycles, and a starved
//               DMA is granted a locked burst while the CPU pipeline stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_last,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_cnt
);

    localparam int c_STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int c_BURST_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT - 1);
    localparam logic [c_BURST_W-1:0]  c_BURST_MAX  = c_BURST_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_BURST_W-1:0]  r_burst_cnt;
    logic [15:0]           r_conflict_cnt;

    logic w_dma_owner;
    logic w_owner_req;
    logic w_owner_we;
    logic w_dma_ack;
    logic w_cpu_stall;

    // DMA owns the port for the whole locked burst, or for a single stolen idle cycle.
    assign w_dma_owner = (r_state == S_DMA) || (!cpu_req && dma_req);
    assign w_owner_req = w_dma_owner ? dma_req : cpu_req;
    assign w_owner_we  = w_dma_owner ? dma_we  : cpu_we;

    assign w_dma_ack   = w_dma_owner && dma_req && !reset;
    assign w_cpu_stall = (r_state == S_DMA) && cpu_req && !reset;

    // Address and data are zeroed when idle so nothing from a non-owner leaks out.
    assign mem_addr  = !w_owner_req ? '0 : (w_dma_owner ? dma_addr  : cpu_addr);
    assign mem_wdata = !w_owner_req ? '0 : (w_dma_owner ? dma_wdata : cpu_wdata);
    assign mem_we    = w_owner_req &&  w_owner_we && !reset;
    assign mem_re    = w_owner_req && !w_owner_we && !reset;

    assign cpu_rdata    = mem_rdata;
    assign dma_rdata    = mem_rdata;
    assign dma_ack      = w_dma_ack;
    assign cpu_stall    = w_cpu_stall;
    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_CPU;
            r_starve_cnt   <= '0;
            r_burst_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_cpu_stall && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end

            case (r_state)
                S_CPU: begin
                    r_burst_cnt <= '0;
                    if (dma_req && !w_dma_ack) begin
                        if (r_starve_cnt == c_STARVE_MAX) begin
                            r_state      <= S_DMA;
                            r_starve_cnt <= '0;
                        end else begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                S_DMA: begin
                    r_starve_cnt <= '0;
                    if (!dma_req || dma_last || (r_burst_cnt == c_BURST_MAX)) begin
                        r_state     <= S_CPU;
                        r_burst_cnt <= '0;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_CPU;
                    r_starve_cnt <= '0;
                    r_burst_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
